// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state/error encodings and request legality helper for mem_req_ctrl
// Contents: state_t (IDLE/WAIT/RESP/ERR), err_code_t (ERR_NONE/ERR_ALIGN/ERR_MEM/ERR_TIMEOUT),
//           req_legal() -- exactly one of rd/wr and an even byte address.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_MEM     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  function automatic logic req_legal(input logic rd, input logic wr, input logic addr_lsb);
    return (rd ^ wr) & ~addr_lsb;
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// rtl/mem_req_ctrl_if.sv - bus between mem_req_ctrl and mem_system
// master: drives mem_addr/mem_wdata/mem_rd/mem_wr, samples mem_rdata/mem_done/mem_stall/mem_hit/mem_err
// slave : mem_system side, the mirror image
interface mem_req_ctrl_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        mem_hit;
  logic        mem_err;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_done, mem_stall, mem_hit, mem_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_done, mem_stall, mem_hit, mem_err
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up counter that holds at all-ones
// Ports: clk, rst (async, active-high), inc (count enable), clr (sync clear, wins over inc), q (count)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - memory-stage request controller: issues one Rd/Wr pulse, stalls until Done, reports errors
// Ports: clk, rst (async, active-high); pipeline side req_rd/req_wr/req_addr/req_wdata in,
//        pipe_stall/resp_valid/rdata out; status err/err_code, statistics access_cnt/hit_cnt;
//        bus (mem_req_ctrl_if.master) towards mem_system.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic              pipe_stall,
  output logic              resp_valid,
  output logic [15:0]       rdata,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  access_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  mem_req_ctrl_if.master    bus
);

  // Last WAIT cycle allowed: counter is 0 in the first WAIT cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  err_code_t       err_code_q, err_code_d;
  logic [15:0]     rdata_q;
  logic [TO_W-1:0] to_cnt;
  logic            any_req, legal, complete, enter_wait;
  logic            rd_c, wr_c, stall_c;
  logic            unused_stall;

  assign any_req = req_rd | req_wr;
  assign legal   = req_legal(req_rd, req_wr, req_addr[0]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; err_code is only ever changed on the way into ERR.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (!legal) begin
            state_d    = ERR;
            err_code_d = ERR_ALIGN;
          end else if (bus.mem_err) begin
            state_d    = ERR;
            err_code_d = ERR_MEM;
          end else if (bus.mem_done) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_err) begin
          state_d    = ERR;
          err_code_d = ERR_MEM;
        end else if (bus.mem_done) begin
          state_d = RESP;
        end else if (to_cnt == TO_LAST) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = ERR;
    endcase
  end

  // Output logic
  always_comb begin
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    stall_c    = 1'b0;
    resp_valid = 1'b0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = any_req;
        if (legal) begin
          rd_c = req_rd;
          wr_c = req_wr;
        end
      end
      WAIT:    stall_c = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: begin
        stall_c = 1'b1;
        err     = 1'b1;
      end
    endcase
  end

  // Strobes and stall must drop the moment rst rises, not at the next edge.
  assign bus.mem_rd    = rd_c & ~rst;
  assign bus.mem_wr    = wr_c & ~rst;
  assign pipe_stall    = stall_c & ~rst;
  assign bus.mem_addr  = req_addr;
  assign bus.mem_wdata = req_wdata;

  // Only IDLE and WAIT can move to RESP, and only on a clean Done.
  assign complete   = (state_d == RESP) && (state_q != RESP);
  assign enter_wait = (state_q == IDLE) && (state_d == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      if (complete && req_rd) begin
        rdata_q <= bus.mem_rdata;
      end
      err_code_q <= err_code_d;
    end
  end

  assign rdata    = rdata_q;
  assign err_code = err_code_q;

  sat_counter #(.W(CNT_W)) u_access_cnt (
    .clk (clk),
    .rst (rst),
    .inc (complete),
    .clr (1'b0),
    .q   (access_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (complete & bus.mem_hit),
    .clr (1'b0),
    .q   (hit_cnt)
  );

  sat_counter #(.W(TO_W)) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .inc (state_q == WAIT),
    .clr (enter_wait),
    .q   (to_cnt)
  );

  // mem_system Stall is informational only here.
  assign unused_stall = bus.mem_stall;

endmodule
